// File: rtl/mem_lsu_if.sv
// Memory bus between the load/store unit and an external RAM with variable latency.
// Latency: none. This file only bundles signals.
// Backpressure: the master holds req and its qualifiers until the slave returns ack.
// Ports (master view):
//   out: req, addr, we, sel, wdata
//   in : ack, rdata
interface mem_lsu_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int BYTES = DATA_W / 8;

  logic              req;
  logic              ack;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [BYTES-1:0]  sel;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (output req, addr, we, sel, wdata, input ack, rdata);
  modport slave  (input req, addr, we, sel, wdata, output ack, rdata);
endinterface

// File: rtl/mem_lsu.sv
// Load/store unit for the memory stage. It decodes the memory op, checks size and alignment,
// runs a req/ack bus cycle with a timeout, and extends the load data for write-back.
// Latency: 1 cycle for non-bus ops; at least 2 cycles (accept, BUS, DONE) for bus ops.
// Backpressure: stall_req_o holds upstream during accept of a bus op and for the whole BUS phase.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   valid_i, mem_op_i, wd_i, wreg_i,  stage inputs (held stable while stall_req_o=1)
//   wdata_i, mem_addr_i, reg2_i
//   wd_o, wreg_o, wdata_o, valid_o    registered write-back fields, valid_o pulses per instruction
//   align_exc_o, illegal_o, bus_err_o fault flags, qualified by valid_o
//   stall_req_o                       combinational pipeline stall
//   mem                               RAM bus (master side)
module mem_lsu #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TMO_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [3:0]        mem_op_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] reg2_i,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              valid_o,
  output logic              align_exc_o,
  output logic              illegal_o,
  output logic              bus_err_o,
  output logic              stall_req_o,
  mem_lsu_if.master         mem
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFS   = $clog2(BYTES);
  localparam int CNT_W = $clog2(TMO_CYC + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] tmo_cnt;

  // Decode of the current input op.
  logic             is_mem;
  logic             illegal;
  logic             misalign;
  logic             bus_op;
  logic [1:0]       sz;
  int               nb;
  int               k;
  logic [BYTES-1:0] sel_c;
  logic [DATA_W-1:0] st_dat_c;

  // Op attributes latched at accept for use when the ack arrives.
  logic [OFS-1:0]   k_q;
  logic [1:0]       sz_q;
  logic             uns_q;
  logic             st_q;
  int               nbq;
  int               kq;
  logic [DATA_W-1:0] ld_raw;
  logic [DATA_W-1:0] ld_ext;

  always_comb begin
    is_mem  = (mem_op_i != 4'b0111);
    illegal = is_mem && (int'(mem_op_i[1:0]) > OFS);
    // Clamp an illegal size so the lane math below stays in range; such ops never reach the bus.
    sz      = illegal ? 2'(OFS) : mem_op_i[1:0];
    k       = int'(mem_addr_i[OFS-1:0]);
    nb      = 1 << sz;
    misalign = is_mem && ((k & (nb - 1)) != 0);
    bus_op   = valid_i && is_mem && !illegal && !misalign;

    // Big-endian lanes: offset j lives at the top of the word. Store data repeats across
    // every nb-byte chunk, so the RAM picks it up through sel no matter where k points.
    sel_c    = '0;
    st_dat_c = '0;
    for (int j = 0; j < BYTES; j++) begin
      sel_c[BYTES-1-j] = (j >= k) && (j < k + nb);
      st_dat_c[DATA_W-1-8*j -: 8] = reg2_i[8*(nb-1-(j & (nb-1))) +: 8];
    end
  end

  always_comb begin
    nbq    = 1 << sz_q;
    kq     = int'(k_q);
    ld_raw = '0;
    for (int m = 0; m < BYTES; m++) begin
      if (m < nbq) begin
        ld_raw[8*(nbq-1-m) +: 8] = mem.rdata[DATA_W-1-8*(kq+m) -: 8];
      end
    end
    ld_ext = '0;
    for (int b = 0; b < DATA_W; b++) begin
      ld_ext[b] = (b < 8*nbq) ? ld_raw[b] : (!uns_q && ld_raw[8*nbq-1]);
    end
  end

  assign stall_req_o = ((state == S_IDLE) && bus_op) || (state == S_BUS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      tmo_cnt     <= '0;
      wd_o        <= '0;
      wreg_o      <= 1'b0;
      wdata_o     <= '0;
      valid_o     <= 1'b0;
      align_exc_o <= 1'b0;
      illegal_o   <= 1'b0;
      bus_err_o   <= 1'b0;
      mem.req     <= 1'b0;
      mem.addr    <= '0;
      mem.we      <= 1'b0;
      mem.sel     <= '0;
      mem.wdata   <= '0;
      k_q         <= '0;
      sz_q        <= '0;
      uns_q       <= 1'b0;
      st_q        <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        S_IDLE: begin
          align_exc_o <= 1'b0;
          illegal_o   <= 1'b0;
          bus_err_o   <= 1'b0;
          if (bus_op) begin
            mem.req   <= 1'b1;
            mem.addr  <= {mem_addr_i[ADDR_W-1:OFS], OFS'(0)};
            mem.we    <= mem_op_i[3];
            mem.sel   <= sel_c;
            mem.wdata <= st_dat_c;
            k_q       <= mem_addr_i[OFS-1:0];
            sz_q      <= sz;
            uns_q     <= mem_op_i[2];
            st_q      <= mem_op_i[3];
            // Stores keep wdata_i; loads overwrite it when the ack arrives.
            wd_o      <= wd_i;
            wreg_o    <= wreg_i;
            wdata_o   <= wdata_i;
            state     <= S_BUS;
          end else if (valid_i) begin
            valid_o     <= 1'b1;
            wd_o        <= wd_i;
            wreg_o      <= wreg_i && !(illegal || misalign);
            wdata_o     <= wdata_i;
            illegal_o   <= illegal;
            align_exc_o <= !illegal && misalign;
          end
        end
        S_BUS: begin
          // Ack wins over a timeout that would expire in the same cycle.
          if (mem.ack || (tmo_cnt == TMO_LAST)) begin
            mem.req   <= 1'b0;
            mem.addr  <= '0;
            mem.we    <= 1'b0;
            mem.sel   <= '0;
            mem.wdata <= '0;
            tmo_cnt   <= '0;
            valid_o   <= 1'b1;
            state     <= S_DONE;
            if (mem.ack) begin
              if (!st_q) wdata_o <= ld_ext;
            end else begin
              bus_err_o <= 1'b1;
              wreg_o    <= 1'b0;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_DONE: begin
          bus_err_o <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: 32-bit and 64-bit instances with a short bus timeout.
// Latency: not applicable.
// Backpressure: the bench plays the RAM and upstream stage, honouring stall_req_o.
module tb_mem_lsu;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  op;
  logic [4:0]  wd;
  logic        wreg;
  logic [31:0] addr;
  logic [63:0] wdat;
  logic [63:0] reg2;
  logic        v32, v64;

  logic [4:0]  wd_o32, wd_o64;
  logic        wreg_o32, wreg_o64;
  logic [31:0] wdata_o32;
  logic [63:0] wdata_o64;
  logic        valid32, valid64, align32, align64, ill32, ill64, berr32, berr64, stall32, stall64;

  int checks = 0;
  int errors = 0;
  int n;
  bit got;

  always #5 clk = ~clk;

  mem_lsu_if #(.DATA_W(32), .ADDR_W(32)) b32 ();
  mem_lsu_if #(.DATA_W(64), .ADDR_W(32)) b64 ();

  mem_lsu #(.DATA_W(32), .ADDR_W(32), .TMO_CYC(4)) u32 (
    .clk(clk), .rst(rst), .valid_i(v32), .mem_op_i(op), .wd_i(wd), .wreg_i(wreg),
    .wdata_i(wdat[31:0]), .mem_addr_i(addr), .reg2_i(reg2[31:0]),
    .wd_o(wd_o32), .wreg_o(wreg_o32), .wdata_o(wdata_o32), .valid_o(valid32),
    .align_exc_o(align32), .illegal_o(ill32), .bus_err_o(berr32), .stall_req_o(stall32),
    .mem(b32.master)
  );

  mem_lsu #(.DATA_W(64), .ADDR_W(32), .TMO_CYC(4)) u64 (
    .clk(clk), .rst(rst), .valid_i(v64), .mem_op_i(op), .wd_i(wd), .wreg_i(wreg),
    .wdata_i(wdat), .mem_addr_i(addr), .reg2_i(reg2),
    .wd_o(wd_o64), .wreg_o(wreg_o64), .wdata_o(wdata_o64), .valid_o(valid64),
    .align_exc_o(align64), .illegal_o(ill64), .bus_err_o(berr64), .stall_req_o(stall64),
    .mem(b64.master)
  );

  task automatic chk(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got_v, exp_v);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; op = 4'b0111; wd = '0; wreg = 1'b0; addr = '0; wdat = '0; reg2 = '0;
    v32 = 1'b0; v64 = 1'b0;
    b32.ack = 1'b0; b32.rdata = '0; b64.ack = 1'b0; b64.rdata = '0;
    tick; tick;
    #1;
    chk("rst_valid32", valid32, 0);
    chk("rst_req32", b32.req, 0);
    chk("rst_wdata32", wdata_o32, 0);
    chk("rst_req64", b64.req, 0);
    chk("rst_valid64", valid64, 0);
    rst = 1'b0;
    tick;

    // LB signed at k=1, ack in third BUS cycle
    op = 4'b0000; addr = 32'h1001; wd = 5'd5; wreg = 1'b1; wdat = 64'h99; v32 = 1'b1; #1;
    chk("t1_stall_acc", stall32, 1);
    chk("t1_req_acc", b32.req, 0);
    tick; #1;
    chk("t1_req", b32.req, 1);
    chk("t1_sel", b32.sel, 4'b0100);
    chk("t1_addr", b32.addr, 32'h1000);
    chk("t1_we", b32.we, 0);
    chk("t1_stall_b1", stall32, 1);
    tick; #1;
    chk("t1_stall_b2", stall32, 1);
    tick; b32.ack = 1'b1; b32.rdata = 32'h12F45678; #1;
    chk("t1_stall_b3", stall32, 1);
    tick; b32.ack = 1'b0; #1;
    chk("t1_valid", valid32, 1);
    chk("t1_wdata", wdata_o32, 32'hFFFFFFF4);
    chk("t1_wd", wd_o32, 5);
    chk("t1_wreg", wreg_o32, 1);
    chk("t1_req_done", b32.req, 0);
    chk("t1_stall_done", stall32, 0);
    v32 = 1'b0;
    tick; #1;
    chk("t1_valid_off", valid32, 0);

    // LHU at k=2, ack in the first BUS cycle
    op = 4'b0101; addr = 32'h2002; v32 = 1'b1;
    tick; b32.ack = 1'b1; b32.rdata = 32'h1234ABCD; #1;
    chk("t2_sel", b32.sel, 4'b0011);
    tick; b32.ack = 1'b0; #1;
    chk("t2_valid", valid32, 1);
    chk("t2_wdata", wdata_o32, 32'h0000ABCD);
    v32 = 1'b0;
    tick;

    // SH at k=2
    op = 4'b1001; addr = 32'h3002; reg2 = 64'h0000BEEF; wdat = 64'h77; wreg = 1'b0; v32 = 1'b1;
    tick; #1;
    chk("t2_sh_data", b32.wdata, 32'hBEEFBEEF);
    chk("t2_sh_sel", b32.sel, 4'b0011);
    chk("t2_sh_we", b32.we, 1);
    b32.ack = 1'b1;
    tick; b32.ack = 1'b0; #1;
    chk("t2_sh_valid", valid32, 1);
    chk("t2_sh_wdata", wdata_o32, 32'h77);
    chk("t2_sh_req", b32.req, 0);
    v32 = 1'b0;
    tick;

    // Misaligned LW then D op on a 32-bit unit
    op = 4'b0010; addr = 32'h4006; wreg = 1'b1; v32 = 1'b1; #1;
    chk("t3_stall", stall32, 0);
    tick; #1;
    chk("t3_valid", valid32, 1);
    chk("t3_align", align32, 1);
    chk("t3_ill0", ill32, 0);
    chk("t3_wreg", wreg_o32, 0);
    chk("t3_req", b32.req, 0);
    op = 4'b0011; addr = 32'h4000; #1;
    chk("t3_d_stall", stall32, 0);
    tick; #1;
    chk("t3_d_valid", valid32, 1);
    chk("t3_d_ill", ill32, 1);
    chk("t3_d_align", align32, 0);
    chk("t3_d_wreg", wreg_o32, 0);
    v32 = 1'b0;
    tick; #1;
    chk("t3_idle_valid", valid32, 0);
    chk("t3_idle_ill", ill32, 0);

    // Timeout with no ack
    op = 4'b0010; addr = 32'h5000; wreg = 1'b1; v32 = 1'b1;
    n = 0; got = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick; #1;
      if (b32.req) n++;
      if (valid32) begin
        chk("t4_berr", berr32, 1);
        chk("t4_wreg", wreg_o32, 0);
        got = 1'b1;
        break;
      end
    end
    chk("t4_req_cycles", n, 4);
    chk("t4_done_seen", got, 1);
    v32 = 1'b0;
    tick; #1;
    chk("t4_berr_clear", berr32, 0);

    // ALU, ALU, load, ALU ordering
    op = 4'b0111; wd = 5'd1; wdat = 64'hA1; wreg = 1'b1; v32 = 1'b1;
    tick; #1;
    chk("t5_a1_valid", valid32, 1);
    chk("t5_a1_wdata", wdata_o32, 32'hA1);
    wd = 5'd2; wdat = 64'hA2;
    tick; #1;
    chk("t5_a2_valid", valid32, 1);
    chk("t5_a2_wd", wd_o32, 2);
    op = 4'b0100; addr = 32'h6003; wd = 5'd3; wdat = 64'h0;
    tick; #1;
    chk("t5_ld_busy", valid32, 0);
    b32.ack = 1'b1; b32.rdata = 32'h112233C3;
    tick; b32.ack = 1'b0; #1;
    chk("t5_ld_valid", valid32, 1);
    chk("t5_ld_wdata", wdata_o32, 32'h000000C3);
    chk("t5_ld_wd", wd_o32, 3);
    tick;
    op = 4'b0111; wd = 5'd4; wdat = 64'hA4;
    tick; #1;
    chk("t5_a4_valid", valid32, 1);
    chk("t5_a4_wdata", wdata_o32, 32'hA4);
    v32 = 1'b0;
    tick;

    // Reset during the second BUS cycle; a late ack must be ignored
    op = 4'b0010; addr = 32'h7000; wd = 5'd7; v32 = 1'b1;
    tick; tick;
    rst = 1'b1; v32 = 1'b0;
    tick; #1;
    chk("t6_req_rst", b32.req, 0);
    chk("t6_valid_rst", valid32, 0);
    rst = 1'b0; b32.ack = 1'b1; b32.rdata = 32'hDEADBEEF;
    tick; b32.ack = 1'b0; #1;
    chk("t6_late_ack_valid", valid32, 0);
    chk("t6_late_ack_req", b32.req, 0);
    op = 4'b0001; addr = 32'h7002; v32 = 1'b1;
    tick; b32.ack = 1'b1; b32.rdata = 32'h00008001; #1;
    chk("t6_lh_req", b32.req, 1);
    tick; b32.ack = 1'b0; #1;
    chk("t6_lh_valid", valid32, 1);
    chk("t6_lh_wdata", wdata_o32, 32'hFFFF8001);
    v32 = 1'b0;
    tick;

    // 64-bit LD at k=0 and LB at k=7
    op = 4'b0011; addr = 32'h8000; wd = 5'd9; v64 = 1'b1;
    tick; #1;
    chk("t7_sel", b64.sel, 8'hFF);
    chk("t7_addr", b64.addr, 32'h8000);
    b64.ack = 1'b1; b64.rdata = 64'h0123456789ABCDEF;
    tick; b64.ack = 1'b0; #1;
    chk("t7_valid", valid64, 1);
    chk("t7_wdata", wdata_o64, 64'h0123456789ABCDEF);
    v64 = 1'b0;
    tick;
    op = 4'b0000; addr = 32'h8007; v64 = 1'b1;
    tick; #1;
    chk("t7_lb_sel", b64.sel, 8'h01);
    chk("t7_lb_addr", b64.addr, 32'h8000);
    b64.ack = 1'b1; b64.rdata = 64'h0123456789ABCDEF;
    tick; b64.ack = 1'b0; #1;
    chk("t7_lb_wdata", wdata_o64, 64'hFFFFFFFFFFFFFFEF);
    v64 = 1'b0;
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
